sram_scan_driver: RTL

On-chip scan master for the SRAM test harness's 112-bit scan chain. It sits directly upstream of the harness, on the logic-analyzer path selected when `in_select` = 0. It accepts one parallel request packet and performs the full transaction. A write transaction shifts the packet in and strobes chip-select. A read transaction additionally loads the SRAM outputs and shifts the 112-bit result back out. The captured packet is returned in parallel.

---
 rtl/sram_scan_pkg.sv | 52 +++++
 rtl/sram_scan_driver_shift_reg.sv | 50 +++++
 rtl/sram_scan_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_pkg.sv
// -----------------------------------------------------------------------------
// sram_scan_pkg
// Shared definitions for the SRAM test-harness scan master.
//   SCAN_LEN_DEFAULT : default scan-chain length (112 bits)
//   *_MSB/*_LSB/*_BIT: field positions inside the 112-bit scan packet
//                      {sel, addr0, din0, csb0, web0, wmask0,
//                       addr1, din1, csb1, web1, wmask1}
//   scan_state_t     : transaction FSM states
//   pack_packet()    : assembles a scan packet from its fields
// -----------------------------------------------------------------------------
package sram_scan_pkg;

    localparam int SCAN_LEN_DEFAULT = 112;

    localparam int SEL_MSB    = 111;
    localparam int ADDR0_LSB  = 92;
    localparam int DIN0_LSB   = 60;
    localparam int CSB0_BIT   = 59;
    localparam int WEB0_BIT   = 58;
    localparam int ADDR1_LSB  = 38;
    localparam int DIN1_LSB   = 6;
    localparam int CSB1_BIT   = 5;
    localparam int WEB1_BIT   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        LOAD   = 3'd4,
        UNLOAD = 3'd5,
        DONE   = 3'd6
    } scan_state_t;

    function automatic logic [SCAN_LEN_DEFAULT-1:0] pack_packet(
        input logic [3:0]  sel,
        input logic [15:0] addr0,
        input logic [31:0] din0,
        input logic        csb0,
        input logic        web0,
        input logic [3:0]  wmask0,
        input logic [15:0] addr1,
        input logic [31:0] din1,
        input logic        csb1,
        input logic        web1,
        input logic [3:0]  wmask1
    );
        return {sel, addr0, din0, csb0, web0, wmask0,
                addr1, din1, csb1, web1, wmask1};
    endfunction

endpackage

// File: rtl/sram_scan_driver_shift_reg.sv
// -----------------------------------------------------------------------------
// scan_shift_reg
// WIDTH-bit register with parallel load, serial-in at the LSB and serial-out
// from the MSB (q[WIDTH-1]). Parallel load has priority over shifting.
//   clk, srst  : clock, synchronous active-high reset
//   load_en    : load load_data
//   load_data  : parallel load value
//   shift_en   : shift left by one, serial_in enters at bit 0
//   serial_in  : serial input
//   q          : register contents
// -----------------------------------------------------------------------------
module scan_shift_reg
    import sram_scan_pkg::*;
#(
    parameter int WIDTH = SCAN_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic shift_src;
            if (gi == 0) begin : g_lsb
                assign shift_src = serial_in;
            end else begin : g_upper
                assign shift_src = q[gi-1];
            end
            assign q_next[gi] = load_en  ? load_data[gi] :
                                shift_en ? shift_src     : q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sram_scan_driver.sv
// -----------------------------------------------------------------------------
// sram_scan_driver
// Scan master for the SRAM harness scan chain. Accepts one parallel request,
// shifts it in MSB-first, strobes global_csb, and for reads loads the SRAM
// outputs and shifts the captured chain back out (re-emitting the request so
// the chain is restored). The capture is returned on resp_packet.
//
// Ports:
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_read, req_packet   : transaction type and scan packet
//   resp_valid             : one-cycle pulse at transaction end
//   resp_packet            : captured chain (updated on reads only)
//   resp_mismatch          : capture != request (reads, with checker built)
//   mismatch_count         : saturating mismatch counter
//   scan_en, scan_data     : serial interface to the harness
//   scan_in                : serial data back from the harness
//   sram_load, global_csb  : SRAM capture strobe, active-low transaction strobe
//
// Build option: define SCAN_DRV_CHECK_EN to build the capture comparator and
// mismatch counter; otherwise resp_mismatch and mismatch_count are tied to 0.
// -----------------------------------------------------------------------------
module sram_scan_driver
    import sram_scan_pkg::*;
#(
    parameter int SCAN_LEN = SCAN_LEN_DEFAULT,
    parameter int CNT_W    = 7
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_read,
    input  logic [SCAN_LEN-1:0] req_packet,
    output logic                resp_valid,
    output logic [SCAN_LEN-1:0] resp_packet,
    output logic                resp_mismatch,
    output logic [15:0]         mismatch_count,
    output logic                scan_en,
    output logic                scan_data,
    input  logic                scan_in,
    output logic                sram_load,
    output logic                global_csb
);

    scan_state_t         state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                rd_reg;
    logic                req_ready_reg;
    logic                resp_valid_reg;
    logic [SCAN_LEN-1:0] resp_packet_reg;
    logic                scan_en_reg;
    logic                scan_data_reg;
    logic                sram_load_reg;
    logic                global_csb_reg;

    logic                accept;
    logic                cnt_last;
    logic                sr_shift;
    logic                sr_serial_in;
    logic [SCAN_LEN-1:0] sr_q;
    logic [SCAN_LEN-1:0] capture;

    assign accept   = (state_reg == IDLE) && req_valid && req_ready_reg;
    assign cnt_last = (cnt_reg == CNT_W'(SCAN_LEN - 1));

    // During SHIFT the register rotates (MSB back into LSB) so that after
    // SCAN_LEN cycles it again holds the request; UNLOAD then shifts the
    // request out of the MSB while the harness capture fills from the LSB.
    assign sr_shift     = (state_reg == SHIFT) || (state_reg == UNLOAD);
    assign sr_serial_in = (state_reg == UNLOAD) ? scan_in : sr_q[SCAN_LEN-1];

    // Full capture including the bit sampled at the final UNLOAD edge.
    assign capture = {sr_q[SCAN_LEN-2:0], scan_in};

    scan_shift_reg #(
        .WIDTH(SCAN_LEN)
    ) u_shift_reg (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .load_en  (accept),
        .load_data(req_packet),
        .shift_en (sr_shift),
        .serial_in(sr_serial_in),
        .q        (sr_q)
    );

    // scan_data is registered one cycle ahead: it takes the bit that will be
    // at the register MSB after the current shift, i.e. sr_q[SCAN_LEN-2].
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            rd_reg          <= 1'b0;
            req_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            resp_packet_reg <= '0;
            scan_en_reg     <= 1'b0;
            scan_data_reg   <= 1'b0;
            sram_load_reg   <= 1'b0;
            global_csb_reg  <= 1'b1;
        end else begin
            resp_valid_reg <= 1'b0;
            sram_load_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg     <= SHIFT;
                        rd_reg        <= req_read;
                        cnt_reg       <= '0;
                        req_ready_reg <= 1'b0;
                        scan_en_reg   <= 1'b1;
                        scan_data_reg <= req_packet[SCAN_LEN-1];
                    end
                end
                SHIFT: begin
                    if (cnt_last) begin
                        state_reg      <= STROBE;
                        cnt_reg        <= '0;
                        scan_en_reg    <= 1'b0;
                        scan_data_reg  <= 1'b0;
                        global_csb_reg <= 1'b0;
                    end else begin
                        cnt_reg       <= cnt_reg + 1'b1;
                        scan_data_reg <= sr_q[SCAN_LEN-2];
                    end
                end
                STROBE: begin
                    global_csb_reg <= 1'b1;
                    cnt_reg        <= '0;
                    if (rd_reg) begin
                        state_reg <= HOLD;
                    end else begin
                        state_reg      <= DONE;
                        resp_valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    state_reg     <= LOAD;
                    cnt_reg       <= '0;
                    sram_load_reg <= 1'b1;
                end
                LOAD: begin
                    state_reg     <= UNLOAD;
                    cnt_reg       <= '0;
                    scan_en_reg   <= 1'b1;
                    scan_data_reg <= sr_q[SCAN_LEN-1];
                end
                UNLOAD: begin
                    if (cnt_last) begin
                        state_reg       <= DONE;
                        cnt_reg         <= '0;
                        scan_en_reg     <= 1'b0;
                        scan_data_reg   <= 1'b0;
                        resp_valid_reg  <= 1'b1;
                        resp_packet_reg <= capture;
                    end else begin
                        cnt_reg       <= cnt_reg + 1'b1;
                        scan_data_reg <= sr_q[SCAN_LEN-2];
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    cnt_reg       <= '0;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_DRV_CHECK_EN
    logic [SCAN_LEN-1:0] req_latched_reg;
    logic                resp_mismatch_reg;
    logic [15:0]         mismatch_count_reg;
    logic                capture_differs;

    assign capture_differs = (capture != req_latched_reg);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            req_latched_reg    <= '0;
            resp_mismatch_reg  <= 1'b0;
            mismatch_count_reg <= '0;
        end else begin
            resp_mismatch_reg <= 1'b0;
            if (accept) begin
                req_latched_reg <= req_packet;
            end
            // Evaluated on the edge entering DONE so the flag lines up
            // with resp_valid.
            if ((state_reg == UNLOAD) && cnt_last) begin
                resp_mismatch_reg <= capture_differs;
                if (capture_differs && (mismatch_count_reg != 16'hFFFF)) begin
                    mismatch_count_reg <= mismatch_count_reg + 16'd1;
                end
            end
        end
    end

    assign resp_mismatch  = resp_mismatch_reg;
    assign mismatch_count = mismatch_count_reg;
`else
    assign resp_mismatch  = 1'b0;
    assign mismatch_count = 16'd0;
`endif

    assign req_ready   = req_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_packet = resp_packet_reg;
    assign scan_en     = scan_en_reg;
    assign scan_data   = scan_data_reg;
    assign sram_load   = sram_load_reg;
    assign global_csb  = global_csb_reg;

endmodule
